// File: rtl/shift_arbiter.sv
// Round-robin shared 32-bit shifter for two requesters.
// One-entry registered result slot with valid/ready.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_dir,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_dir,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  typedef struct packed {
    logic             dir;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data;
  } req_t;

  slot_e            state_q;
  slot_e            state_d;
  logic             last_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;

  logic slot_free;
  logic win0;
  logic win1;
  logic acc;
  logic sel;
  req_t r0;
  req_t r1;
  req_t rs;

  // dir=0: arithmetic right, dir=1: logical left
  function automatic logic [WIDTH-1:0] shift(input req_t r);
    logic big;
    big = (r.amt >= AMT_W'(WIDTH));
    if (r.dir) begin
      shift = big ? '0 : (r.data << r.amt);
    end else begin
      shift = big ? {WIDTH{r.data[WIDTH-1]}}
                  : WIDTH'($signed(r.data) >>> r.amt);
    end
  endfunction

  assign r0 = '{dir: req0_dir, amt: req0_amt, data: req0_data};
  assign r1 = '{dir: req1_dir, amt: req1_amt, data: req1_data};

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign slot_free = !rsp_valid || rsp_ready;

  // last_q=1 means requester 1 was granted last
  assign win0 = req0_valid && (!req1_valid || last_q);
  assign win1 = req1_valid && (!req0_valid || !last_q);

  // readys are gated by reset so nothing is offered during it
  assign req0_ready = rst_n && slot_free && win0;
  assign req1_ready = rst_n && slot_free && win1;

  assign acc = req0_ready || req1_ready;
  assign sel = req1_ready;
  assign rs  = sel ? r1 : r0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (acc) state_d = FULL;
      FULL: begin
        if (acc) state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        data_q <= shift(rs);
        id_q   <= sel;
        last_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter.
// Reference model plus directed literal checks.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic        req0_dir = 1'b0;
  logic [31:0] req0_amt = '0;
  logic [31:0] req0_data = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic        req1_dir = 1'b0;
  logic [31:0] req1_amt = '0;
  logic [31:0] req1_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_id;

  int vectors = 0;
  int miscompares = 0;

  shift_arbiter #(.WIDTH(32), .AMT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dir(req0_dir), .req0_amt(req0_amt),
    .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dir(req1_dir), .req1_amt(req1_amt),
    .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint pow2(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 2;
    return p;
  endfunction

  // shift expressed as division / multiplication by powers of two
  function automatic logic [31:0] m_shift(input logic [31:0] d,
                                          input logic dir,
                                          input logic [31:0] amt);
    longint v, p, q;
    if (dir) begin
      if (amt >= 32) return 32'h0;
      q = (longint'(d) % pow2(32 - int'(amt))) * pow2(int'(amt));
      return q[31:0];
    end
    v = longint'($signed(d));
    if (amt >= 32) return (v < 0) ? 32'hFFFF_FFFF : 32'h0;
    p = pow2(int'(amt));
    if (v >= 0) q = v / p;
    else q = -((-v + p - 1) / p);
    return q[31:0];
  endfunction

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_id;
  logic        m_last;

  function automatic logic m_grant0();
    return req0_valid && !(req1_valid && m_last == 1'b0);
  endfunction

  function automatic logic m_grant1();
    return req1_valid && !(req0_valid && m_last == 1'b1);
  endfunction

  function automatic logic m_free();
    return rst_n && (!m_valid || rsp_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 1'b0;
      m_last  <= 1'b1;
    end else if (m_free() && m_grant0()) begin
      m_valid <= 1'b1;
      m_data  <= m_shift(req0_data, req0_dir, req0_amt);
      m_id    <= 1'b0;
      m_last  <= 1'b0;
    end else if (m_free() && m_grant1()) begin
      m_valid <= 1'b1;
      m_data  <= m_shift(req1_data, req1_dir, req1_amt);
      m_id    <= 1'b1;
      m_last  <= 1'b1;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("m_req0_ready", 32'(req0_ready), 32'(m_free() && m_grant0()));
    chk("m_req1_ready", 32'(req1_ready), 32'(m_free() && m_grant1()));
    if (m_valid || !rst_n) begin
      chk("m_rsp_data", rsp_data, m_data);
      chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
    end
  end

  typedef struct {
    logic [31:0] d;
    logic        dir;
    logic [31:0] amt;
    logic [31:0] exp;
  } vec_t;

  vec_t bv[8];

  initial begin
    bv[0] = '{32'h8000_0000, 1'b0, 32'd32, 32'hFFFF_FFFF};
    bv[1] = '{32'h7FFF_FFFF, 1'b0, 32'd40, 32'h0000_0000};
    bv[2] = '{32'hFFFF_FFFF, 1'b1, 32'd32, 32'h0000_0000};
    bv[3] = '{32'hA5A5_A5A5, 1'b0, 32'd0,  32'hA5A5_A5A5};
    bv[4] = '{32'hA5A5_A5A5, 1'b1, 32'd0,  32'hA5A5_A5A5};
    bv[5] = '{32'h8000_0000, 1'b0, 32'd31, 32'hFFFF_FFFF};
    bv[6] = '{32'h0000_0001, 1'b1, 32'd31, 32'h8000_0000};
    bv[7] = '{32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // reset with a pending request: ready must stay low
    #1 rst_n = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 32'h8000_0000;
    req0_dir   = 1'b0;
    req0_amt   = 32'd1;
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1 req0_amt = 32'd2;
    @(negedge clk);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data1", rsp_data, 32'hC000_0000);
    chk("t1_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_data2", rsp_data, 32'hE000_0000);

    // fresh reset, then both requesters streaming
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h1;
    req0_dir = 1'b1; req0_amt = 32'd4;
    req1_valid = 1'b1; req1_data = 32'hFFFF_FFF0;
    req1_dir = 1'b0; req1_amt = 32'd4;
    @(negedge clk);
    chk("t2_first0", 32'(req0_ready), 32'd1);
    chk("t2_first1", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(rsp_valid), 32'd1);
      chk("t2_id", 32'(rsp_id), 32'(i % 2));
      chk("t2_data", rsp_data,
          (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0010);
      chk("t2_r1", 32'(req1_ready), 32'(i % 2 == 0));
    end

    // backpressure
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1
    req0_valid = 1'b1; req0_data = 32'h1234_5678;
    req0_dir = 1'b1; req0_amt = 32'd0;
    rsp_ready = 1'b0;
    @(posedge clk); #1
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0000_00F0;
    req1_dir = 1'b0; req1_amt = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_data", rsp_data, 32'h1234_5678);
      chk("t3_hold_id", 32'(rsp_id), 32'd0);
      chk("t3_hold_r1", 32'(req1_ready), 32'd0);
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_rel_r1", 32'(req1_ready), 32'd1);
    chk("t3_rel_data", rsp_data, 32'h1234_5678);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("t3_new_data", rsp_data, 32'h0000_000F);
    chk("t3_new_id", 32'(rsp_id), 32'd1);

    // boundary amounts
    foreach (bv[k]) begin
      @(posedge clk); #1
      req0_valid = 1'b1; req0_data = bv[k].d;
      req0_dir = bv[k].dir; req0_amt = bv[k].amt;
      @(negedge clk);
      chk("t4_ready", 32'(req0_ready), 32'd1);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      chk("t4_data", rsp_data, bv[k].exp);
    end

    // asynchronous reset with a full slot and two pending requests
    @(posedge clk); #1
    req0_valid = 1'b1; req0_data = 32'h1;
    req0_dir = 1'b1; req0_amt = 32'd1;
    rsp_ready = 1'b0;
    @(posedge clk); #1
    req1_valid = 1'b1; req1_data = 32'h10;
    req1_dir = 1'b0; req1_amt = 32'd4;
    @(negedge clk);
    chk("t5_pre_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_r0", 32'(req0_ready), 32'd0);
    chk("t5_rst_r1", 32'(req1_ready), 32'd0);
    chk("t5_rst_data", rsp_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_r0", 32'(req0_ready), 32'd1);
    chk("t5_r1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("t5_id0", 32'(rsp_id), 32'd0);
    chk("t5_data0", rsp_data, 32'h2);
    chk("t5_r1b", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("t5_id1", 32'(rsp_id), 32'd1);
    chk("t5_data1", rsp_data, 32'h1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
